// File: rtl/matmul_stream_driver_if.sv
// rtl/matmul_stream_driver_if.sv - input/output streams and bus master signals of matmul_stream_driver
interface matmul_stream_driver_if #(
  parameter int unsigned OUT_W = 18
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             err;
  logic [31:0]      bus_addr;
  logic             bus_wr_en;
  logic             bus_rd_en;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;

  modport master (
    input  in_data, in_valid, out_ready, bus_rdata,
    output in_ready, out_data, out_valid, out_last, busy, err,
    output bus_addr, bus_wr_en, bus_rd_en, bus_wdata
  );

  modport slave (
    output in_data, in_valid, out_ready, bus_rdata,
    input  in_ready, out_data, out_valid, out_last, busy, err,
    input  bus_addr, bus_wr_en, bus_rd_en, bus_wdata
  );
endinterface

// File: rtl/matmul_stream_driver.sv
// rtl/matmul_stream_driver.sv - streams a 4x4 matrix + vector into the matrix-vector unit and streams results out
// Optional poll timeout enabled by defining MATMUL_DRV_TIMEOUT_EN.
module matmul_stream_driver #(
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned OUT_W          = 18
) (
  input logic                   clk,
  input logic                   reset,
  matmul_stream_driver_if.master io
);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_GAP, S_POLL, S_CHK, S_RD, S_CAP, S_EMIT
  } state_e;

  localparam logic [31:0] A_START = BASE_ADDR + 32'd20;
  localparam logic [31:0] A_OUT   = BASE_ADDR + 32'd32;
  localparam logic [31:0] A_DONE  = BASE_ADDR + 32'd36;

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [1:0]       res_q, res_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic             bus_wr_en_q, bus_wr_en_d;
  logic             bus_rd_en_q, bus_rd_en_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;
  logic             in_ready;
  logic             accept;
  logic             tmo_hit;
  logic             unused_rdata;

  assign in_ready     = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept       = in_ready && io.in_valid;
  assign unused_rdata = ^io.bus_rdata;

`ifdef MATMUL_DRV_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // START always leads into GAP, so clearing there is "clear on entering GAP".
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_START) begin
      tmo_d = '0;
    end else if ((state_q == S_POLL) || (state_q == S_CHK)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  assign tmo_hit = ((state_q == S_POLL) || (state_q == S_CHK)) &&
                   ((32'(tmo_q) + 32'd1) >= TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Bus fields computed here appear on the registered bus in the following cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    res_d       = res_q;
    bus_addr_d  = '0;
    bus_wdata_d = '0;
    bus_wr_en_d = 1'b0;
    bus_rd_en_d = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          bus_wr_en_d = 1'b1;
          bus_addr_d  = BASE_ADDR + 32'(idx_q);
          bus_wdata_d = {24'd0, io.in_data};
          idx_d       = idx_q + 5'd1;
          state_d     = (idx_q == 5'd19) ? S_START : S_LOAD;
        end
      end
      S_START: begin
        bus_wr_en_d = 1'b1;
        bus_addr_d  = A_START;
        bus_wdata_d = 32'd1;
        idx_d       = '0;
        state_d     = S_GAP;
      end
      S_GAP: begin
        bus_rd_en_d = 1'b1;
        bus_addr_d  = A_DONE;
        state_d     = S_POLL;
      end
      S_POLL: state_d = S_CHK;
      S_CHK: begin
        bus_rd_en_d = 1'b1;
        if (io.bus_rdata[0]) begin
          bus_addr_d = A_OUT;
          res_d      = 2'd0;
          state_d    = S_RD;
        end else begin
          bus_addr_d = A_DONE;
          state_d    = S_POLL;
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        out_data_d  = io.bus_rdata[OUT_W-1:0];
        out_valid_d = 1'b1;
        out_last_d  = (res_q == 2'd3);
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (res_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            res_d       = res_q + 2'd1;
            bus_rd_en_d = 1'b1;
            bus_addr_d  = A_OUT + 32'(res_q + 2'd1);
            state_d     = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d     = S_IDLE;
      err_d       = 1'b1;
      bus_rd_en_d = 1'b0;
      bus_addr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      res_q       <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wr_en_q <= 1'b0;
      bus_rd_en_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wr_en_q <= bus_wr_en_d;
      bus_rd_en_q <= bus_rd_en_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.busy      = (state_q != S_IDLE);
  assign io.err       = err_q;
  assign io.out_data  = out_data_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_wdata = bus_wdata_q;
  assign io.bus_wr_en = bus_wr_en_q;
  assign io.bus_rd_en = bus_rd_en_q;
endmodule
